axis_gear_pack: RTL
===================

// Module: axis_gear_pack
// PURPOSE
//  AXI4-Stream width packer: accepts IN_W-bit beats and emits OUT_W-bit beats (IN_W < OUT_W), any ratio.
//  Inverse of the narrowing gear box; used on receive paths to repack e.g. 14-bit samples into 16-bit words.
//  Bit order little-endian: first input beat occupies output LSBs; bits carry across output boundaries.
//  Honours tlast: residue is zero-padded, flushed, and the final output beat carries tlast.
// PARAMETERS
//  IN_W   14  input data width in bits (1 <= IN_W < OUT_W)
//  OUT_W  16  output data width in bits
// PORTS
//  aclk             in   1      clock, all logic rising-edge
//  areset           in   1      reset, asynchronous, active-high
//  axis_in.tvalid   in   1      input beat valid
//  axis_in.tready   out  1      input beat accepted when tvalid & tready
//  axis_in.tdata    in   IN_W   input data, bits [IN_W-1:0] used
//  axis_in.tlast    in   1      last beat of packet; triggers flush
//  axis_out.tvalid  out  1      output beat valid (registered)
//  axis_out.tready  in   1      downstream ready
//  axis_out.tdata   out  OUT_W  packed output data (registered)
//  axis_out.tlast   out  1      final beat of packet (registered)
// BEHAVIOUR
//  State: acc[OUT_W+IN_W-2:0], fill (bits valid in acc, 0..OUT_W+IN_W-1), flush flag, output register.
//  Reset (async, areset=1): fill=0, acc=0, flush=0, axis_out.tvalid=0, tdata=0, tlast=0; axis_in.tready=0 while areset.
//  out_free = ~axis_out.tvalid | axis_out.tready.
//  load = out_free & (fill >= OUT_W | (flush & fill != 0)).
//  axis_in.tready = ~flush & (fill < OUT_W | load) -- combinational path from axis_out.tready is permitted.
//  wr_en = axis_in.tvalid & axis_in.tready.
//  On load: out.tdata <= acc[OUT_W-1:0] with bits at/above fill forced 0 (pad); acc >>= OUT_W;
//    fill <= (fill > OUT_W) ? fill-OUT_W : 0; out.tvalid <= 1;
//    out.tlast <= flush & (fill <= OUT_W).
//  On out.tvalid & out.tready without load: out.tvalid <= 0.
//  On wr_en: tdata written into acc at bit offset fill (post-load fill if load same cycle); fill += IN_W.
//  Simultaneous load and wr_en in one cycle required (full throughput: no bubbles while downstream ready).
//  tlast accepted: flush <= 1; no further input until flush clears.
//  Flush clears on the load that sets out.tlast=1; tready may rise the following cycle.
//  Exact boundary: if fill hits 0 exactly on a full word, that word carries tlast; no extra padded beat.
//  tlast with fill==0 after write impossible (IN_W>=1), so every packet yields >=1 output beat.
//  Latency: completing input beat -> out.tvalid two aclk edges later (fill registered, then output reg).
//  Output register holds tdata/tlast stable while tvalid & ~tready (AXIS rule).
//  Throughput: OUT_W/IN_W input beats per output beat, sustained 1 input/clk when downstream always ready.
//  Mid-operation reset discards acc and pending output; no partial beat emitted after release.
// TESTING
//  1) IN_W=14,OUT_W=16: 8 beats 14'h3FFF, tlast on 8th, out.tready=1 -> 7 beats 16'hFFFF, tlast only on 7th, no input stalls.
//  2) Beats 14'h3FFF,14'h0003 (tlast) -> out 16'hFFFF, then 16'h0000 with tlast=1 (residue 12 bits, zero-padded).
//  3) Single beat 14'h1234 with tlast -> exactly one out beat 16'h1234, tlast=1; in.tready low until after it loads.
//  4) IN_W=8,OUT_W=16: beats 8'hAA,8'h55 (tlast) -> one beat 16'h55AA tlast=1, no extra padded beat.
//  5) Random stream, out.tready low 20 cycles: in.tready drops once fill>=16 and out valid; stable out data; no loss/dup vs model.
//  6) areset asserted after 3 beats mid-packet -> tvalid=0 immediately; new packet after release packs from bit 0.

Source files
------------

// File: rtl/axis_gear_pack.sv
// axis_gear_pack: AXI4-Stream width packer (narrow in, wide out).
//
// Accepts IN_W-bit beats and emits OUT_W-bit beats (IN_W < OUT_W, any ratio).
// Bits are packed little-endian: the first input beat lands in the output LSBs,
// and bits carry across output word boundaries. When an input beat with tlast
// is accepted, the residue is zero-padded and flushed, and the final output
// beat carries tlast.
//
// Ports:
//   aclk        in   1      clock, rising edge
//   areset      in   1      asynchronous active-high reset
//   in_tvalid   in   1      input beat valid
//   in_tready   out  1      input beat accepted when in_tvalid & in_tready
//   in_tdata    in   IN_W   input data
//   in_tlast    in   1      last input beat of packet, starts a flush
//   out_tvalid  out  1      output beat valid (registered)
//   out_tready  in   1      downstream ready
//   out_tdata   out  OUT_W  packed output data (registered)
//   out_tlast   out  1      final output beat of packet (registered)

module axis_gear_pack #(
    parameter int unsigned IN_W  = 14,
    parameter int unsigned OUT_W = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             in_tvalid,
    output logic             in_tready,
    input  logic [IN_W-1:0]  in_tdata,
    input  logic             in_tlast,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic [OUT_W-1:0] out_tdata,
    output logic             out_tlast
);

    // The accumulator never holds more than OUT_W+IN_W-1 valid bits: a write is
    // only allowed while fill < OUT_W, or in the same cycle a word is drained.
    localparam int unsigned ACC_W  = OUT_W + IN_W - 1;
    localparam int unsigned FILL_W = $clog2(OUT_W + IN_W);

    localparam logic [FILL_W-1:0] FILL_OUT = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] FILL_IN  = FILL_W'(IN_W);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              flush_q, flush_d;
    logic              out_tvalid_q, out_tvalid_d;
    logic [OUT_W-1:0]  out_tdata_q, out_tdata_d;
    logic              out_tlast_q, out_tlast_d;

    logic              out_free;
    logic              load;
    logic              last_word;
    logic              wr_en;
    logic [FILL_W-1:0] fill_base;
    logic [ACC_W-1:0]  acc_base;
    logic [ACC_W-1:0]  wr_data;
    logic [OUT_W-1:0]  pad_mask;

    // Handshake and drain decisions
    always_comb begin
        out_free  = ~out_tvalid_q | out_tready;
        load      = out_free & ((fill_q >= FILL_OUT) | (flush_q & (fill_q != '0)));
        // During a flush, the word that empties the accumulator is the packet's last.
        last_word = flush_q & (fill_q <= FILL_OUT);
        in_tready = ~areset & ~flush_q & ((fill_q < FILL_OUT) | load);
        wr_en     = in_tvalid & in_tready;
    end

    // Zero any output bit that is not backed by valid accumulator data.
    always_comb begin
        pad_mask = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            pad_mask[i] = (i < int'(fill_q));
        end
    end

    // Accumulator and fill: drain first, then append the new beat at the
    // post-drain fill so a load and a write can share one cycle.
    always_comb begin
        fill_base = fill_q;
        acc_base  = acc_q;
        if (load) begin
            fill_base = (fill_q > FILL_OUT) ? (fill_q - FILL_OUT) : '0;
            acc_base  = acc_q >> OUT_W;
        end
        wr_data = ACC_W'(in_tdata) << fill_base;
        acc_d   = acc_base;
        fill_d  = fill_base;
        if (wr_en) begin
            // Bits at/above fill are always zero, so OR-in is a clean insert.
            acc_d  = acc_base | wr_data;
            fill_d = fill_base + FILL_IN;
        end
    end

    // Flush flag: set by an accepted tlast, cleared by the load that emits tlast.
    always_comb begin
        flush_d = flush_q;
        if (load && last_word) begin
            flush_d = 1'b0;
        end
        if (wr_en && in_tlast) begin
            flush_d = 1'b1;
        end
    end

    // Output register: holds its contents while valid and not ready.
    always_comb begin
        out_tvalid_d = out_tvalid_q;
        out_tdata_d  = out_tdata_q;
        out_tlast_d  = out_tlast_q;
        if (load) begin
            out_tvalid_d = 1'b1;
            out_tdata_d  = acc_q[OUT_W-1:0] & pad_mask;
            out_tlast_d  = last_word;
        end else if (out_tvalid_q && out_tready) begin
            out_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            acc_q        <= '0;
            fill_q       <= '0;
            flush_q      <= 1'b0;
            out_tvalid_q <= 1'b0;
            out_tdata_q  <= '0;
            out_tlast_q  <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            flush_q      <= flush_d;
            out_tvalid_q <= out_tvalid_d;
            out_tdata_q  <= out_tdata_d;
            out_tlast_q  <= out_tlast_d;
        end
    end

    assign out_tvalid = out_tvalid_q;
    assign out_tdata  = out_tdata_q;
    assign out_tlast  = out_tlast_q;

endmodule
